// File: rtl/aes_key_loader_if.sv
// Key-word bus between the key feeder (master) and aes_key_loader (slave),
// together with the active-key outputs that go to the AES-256 key scheduler.
interface aes_key_loader_if #(
    parameter int NB_BUS = 64,
    parameter int NB_KEY = 256
);
    logic [NB_BUS-1:0] i_word;
    logic              i_word_valid;
    logic              i_word_last;
    logic              o_word_ready;
    logic              i_key_switch;
    logic [NB_KEY-1:0] o_key;
    logic              o_key_valid;
    logic              o_keys_stable;
    logic              o_load_error;

    modport master (
        output i_word, i_word_valid, i_word_last, i_key_switch,
        input  o_word_ready, o_key, o_key_valid, o_keys_stable, o_load_error
    );

    modport slave (
        input  i_word, i_word_valid, i_word_last, i_key_switch,
        output o_word_ready, o_key, o_key_valid, o_keys_stable, o_load_error
    );
endinterface

// File: rtl/aes_key_loader.sv
// Double-buffered AES-256 key loader: stages bus words, commits on a frame-boundary switch.
// Optional macro AES_KEY_LOADER_ZEROIZE_EN clears staging on reset, after commit and after a load error.
module aes_key_loader #(
    parameter int NB_BYTE       = 8,
    parameter int N_BYTES_KEY   = 32,
    parameter int NB_BUS        = 64,
    parameter int SCHED_LATENCY = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    aes_key_loader_if.slave bus
);
    localparam int NB_KEY  = N_BYTES_KEY * NB_BYTE;
    localparam int N_WORDS = NB_KEY / NB_BUS;
    localparam int WCW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int SCW     = (SCHED_LATENCY > 2) ? $clog2(SCHED_LATENCY - 1) : 1;

    if (NB_BYTE != 8) begin : g_bad_byte
        $error("aes_key_loader: NB_BYTE must be 8");
    end
    if ((NB_KEY % NB_BUS) != 0) begin : g_bad_bus
        $error("aes_key_loader: key width must be a multiple of NB_BUS");
    end
    if (SCHED_LATENCY < 1) begin : g_bad_lat
        $error("aes_key_loader: SCHED_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {
        FILL,
        PENDING,
        COMMIT,
        SETTLE
    } state_t;

    state_t            state_q;
    logic [WCW-1:0]    wcnt_q;
    logic [SCW-1:0]    settle_q;
    logic [NB_KEY-1:0] staging_q;
    logic [NB_KEY-1:0] staging_d;
    logic [NB_KEY-1:0] key_q;
    logic              ready_q;
    logic              key_valid_q;
    logic              stable_q;
    logic              error_q;

    logic xfer;
    logic at_last_word;
    logic bad_xfer;

    // ready_q is high exactly while in FILL, so it doubles as the state qualifier
    assign xfer         = bus.i_word_valid && ready_q;
    assign at_last_word = (wcnt_q == WCW'(N_WORDS - 1));
    assign bad_xfer     = xfer && (bus.i_word_last != at_last_word);

    always_comb begin
        staging_d = staging_q;
        for (int unsigned k = 0; k < N_WORDS; k++) begin
            if (wcnt_q == WCW'(k)) begin
                staging_d[(N_WORDS - 1 - k) * NB_BUS +: NB_BUS] = bus.i_word;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            settle_q    <= '0;
            key_q       <= '0;
            ready_q     <= 1'b1;
            key_valid_q <= 1'b0;
            stable_q    <= 1'b0;
            error_q     <= 1'b0;
`ifdef AES_KEY_LOADER_ZEROIZE_EN
            staging_q   <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
            case (state_q)
                FILL: begin
                    if (bad_xfer) begin
                        wcnt_q  <= '0;
                        error_q <= 1'b1;
`ifdef AES_KEY_LOADER_ZEROIZE_EN
                        staging_q <= '0;
`else
                        staging_q <= staging_d;
`endif
                    end else if (xfer && at_last_word) begin
                        staging_q <= staging_d;
                        wcnt_q    <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= PENDING;
                    end else if (xfer) begin
                        staging_q <= staging_d;
                        wcnt_q    <= wcnt_q + 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.i_key_switch) begin
                        key_q       <= staging_q;
                        key_valid_q <= 1'b1;
                        stable_q    <= 1'b0;
                        state_q     <= COMMIT;
                    end
                end
                COMMIT: begin
`ifdef AES_KEY_LOADER_ZEROIZE_EN
                    staging_q <= '0;
`endif
                    if (SCHED_LATENCY > 1) begin
                        // SETTLE spends SCHED_LATENCY-1 cycles: counts down to zero inclusive
                        settle_q <= SCW'(SCHED_LATENCY - 2);
                        state_q  <= SETTLE;
                    end else begin
                        ready_q  <= 1'b1;
                        stable_q <= 1'b1;
                        state_q  <= FILL;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        ready_q  <= 1'b1;
                        stable_q <= 1'b1;
                        state_q  <= FILL;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_word_ready  = ready_q;
    assign bus.o_key         = key_q;
    assign bus.o_key_valid   = key_valid_q;
    assign bus.o_keys_stable = stable_q;
    assign bus.o_load_error  = error_q;
endmodule

// File: tb/tb_aes_key_loader.sv
// Directed bench for aes_key_loader: table of per-cycle vectors on a SCHED_LATENCY=1
// instance, plus hand sequences for settle timing and reset on a SCHED_LATENCY=3 instance.
module tb_aes_key_loader;
    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_C = 256'h1111111111111111222222222222222233333333333333334444444444444444;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] word;
    logic        valid;
    logic        last;
    logic        sw;

    int errors = 0;
    int checks = 0;

    aes_key_loader_if #(.NB_BUS(64), .NB_KEY(256)) if1 ();
    aes_key_loader_if #(.NB_BUS(64), .NB_KEY(256)) if3 ();

    assign if1.i_word       = word;
    assign if1.i_word_valid = valid;
    assign if1.i_word_last  = last;
    assign if1.i_key_switch = sw;
    assign if3.i_word       = word;
    assign if3.i_word_valid = valid;
    assign if3.i_word_last  = last;
    assign if3.i_key_switch = sw;

    aes_key_loader #(.NB_BYTE(8), .N_BYTES_KEY(32), .NB_BUS(64), .SCHED_LATENCY(1)) d1 (
        .i_clock(clk), .i_reset(rst), .bus(if1)
    );
    aes_key_loader #(.NB_BYTE(8), .N_BYTES_KEY(32), .NB_BUS(64), .SCHED_LATENCY(3)) d3 (
        .i_clock(clk), .i_reset(rst), .bus(if3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic        v;
        logic        l;
        logic        sw;
        logic        ready;
        logic        kv;
        logic        st;
        logic        err;
        int          key;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] wA[4];
    logic [63:0] wC[4];

    function automatic void add(logic [63:0] w, logic v, logic l, logic s,
                                logic r, logic kv, logic st, logic err, int key);
        vec_t e;
        e.word = w; e.v = v; e.l = l; e.sw = s;
        e.ready = r; e.kv = kv; e.st = st; e.err = err; e.key = key;
        tbl.push_back(e);
    endfunction

    function automatic logic [255:0] keyval(int sel);
        case (sel)
            1:       return KEY_A;
            2:       return KEY_C;
            3:       return '1;
            default: return '0;
        endcase
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        word = '0; valid = 1'b0; last = 1'b0; sw = 1'b0;
    endtask

    task automatic load3(logic [63:0] w0, logic [63:0] w1, logic [63:0] w2, logic [63:0] w3);
        logic [63:0] ws[4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int k = 0; k < 4; k++) begin
            word = ws[k]; valid = 1'b1; last = (k == 3); sw = 1'b0;
            step();
        end
        idle();
    endtask

    initial begin
        wA[0] = 64'h0001020304050607; wA[1] = 64'h08090a0b0c0d0e0f;
        wA[2] = 64'h1011121314151617; wA[3] = 64'h18191a1b1c1d1e1f;
        wC[0] = 64'h1111111111111111; wC[1] = 64'h2222222222222222;
        wC[2] = 64'h3333333333333333; wC[3] = 64'h4444444444444444;

        // nominal load of A, switch, settle
        for (int k = 0; k < 4; k++) add(wA[k], 1, (k == 3), 0, (k != 3), 0, 0, 0, 0);
        add('0, 0, 0, 0, 0, 0, 0, 0, 0);
        add('0, 0, 0, 1, 0, 1, 0, 0, 1);
        add('0, 0, 0, 0, 1, 0, 1, 0, 1);
        // early last, then clean load of C and commit
        add(wA[0], 1, 0, 0, 1, 0, 1, 0, 1);
        add(wA[1], 1, 1, 0, 1, 0, 1, 1, 1);
        add('0, 0, 0, 0, 1, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) add(wC[k], 1, (k == 3), 0, (k != 3), 0, 1, 0, 1);
        add('0, 0, 0, 1, 0, 1, 0, 0, 2);
        add('0, 0, 0, 0, 1, 0, 1, 0, 2);
        // missing last: error on 4th word, switch afterwards ignored
        for (int k = 0; k < 4; k++) add(wA[k], 1, 0, 0, 1, 0, 1, (k == 3), 2);
        add('0, 0, 0, 1, 1, 0, 1, 0, 2);
        add('0, 0, 0, 0, 1, 0, 1, 0, 2);
        // switch during FILL ignored, load completes into PENDING
        add(wA[0], 1, 0, 0, 1, 0, 1, 0, 2);
        add(wA[1], 1, 0, 0, 1, 0, 1, 0, 2);
        add('0, 0, 0, 1, 1, 0, 1, 0, 2);
        add(wA[2], 1, 0, 0, 1, 0, 1, 0, 2);
        add(wA[3], 1, 1, 0, 0, 0, 1, 0, 2);
        for (int k = 0; k < 3; k++) add('0, 0, 0, 0, 0, 0, 1, 0, 2);
        add('0, 0, 0, 1, 0, 1, 0, 0, 1);
        add('0, 0, 0, 0, 1, 0, 1, 0, 1);
        // double buffering: B staged while A stays active; words offered in PENDING are dropped
        for (int k = 0; k < 4; k++) add('1, 1, (k == 3), 0, (k != 3), 0, 1, 0, 1);
        for (int k = 0; k < 10; k++) add(64'hdeadbeefdeadbeef, 1, 1, 0, 0, 0, 1, 0, 1);
        add('0, 0, 0, 1, 0, 1, 0, 0, 3);
        add('0, 0, 0, 0, 1, 0, 1, 0, 3);

        // reset with competing inputs: reset wins
        rst = 1'b1; word = wA[0]; valid = 1'b1; last = 1'b1; sw = 1'b1;
        step();
        check("rst ready", 256'(if1.o_word_ready), 256'(1));
        check("rst key", if1.o_key, '0);
        check("rst kv", 256'(if1.o_key_valid), '0);
        check("rst stable", 256'(if1.o_keys_stable), '0);
        check("rst err", 256'(if1.o_load_error), '0);
        check("rst3 ready", 256'(if3.o_word_ready), 256'(1));
        rst = 1'b0;
        idle();

        foreach (tbl[i]) begin
            word = tbl[i].word; valid = tbl[i].v; last = tbl[i].l; sw = tbl[i].sw;
            step();
            check($sformatf("row%0d ready", i), 256'(if1.o_word_ready), 256'(tbl[i].ready));
            check($sformatf("row%0d kv", i), 256'(if1.o_key_valid), 256'(tbl[i].kv));
            check($sformatf("row%0d stable", i), 256'(if1.o_keys_stable), 256'(tbl[i].st));
            check($sformatf("row%0d err", i), 256'(if1.o_load_error), 256'(tbl[i].err));
            check($sformatf("row%0d key", i), if1.o_key, keyval(tbl[i].key));
        end

        // SCHED_LATENCY=3: stable drops for exactly three cycles after the switch
        idle(); rst = 1'b1; step(); rst = 1'b0;
        load3(wA[0], wA[1], wA[2], wA[3]);
        check("l3 pending ready", 256'(if3.o_word_ready), '0);
        sw = 1'b1; step(); sw = 1'b0;
        check("l3 T+1 key", if3.o_key, KEY_A);
        check("l3 T+1 kv", 256'(if3.o_key_valid), 256'(1));
        check("l3 T+1 stable", 256'(if3.o_keys_stable), '0);
        step();
        check("l3 T+2 kv", 256'(if3.o_key_valid), '0);
        check("l3 T+2 stable", 256'(if3.o_keys_stable), '0);
        check("l3 T+2 ready", 256'(if3.o_word_ready), '0);
        step();
        check("l3 T+3 stable", 256'(if3.o_keys_stable), '0);
        check("l3 T+3 ready", 256'(if3.o_word_ready), '0);
        step();
        check("l3 T+4 stable", 256'(if3.o_keys_stable), 256'(1));
        check("l3 T+4 ready", 256'(if3.o_word_ready), 256'(1));

        // reset two cycles after a switch aborts the settle
        load3('1, '1, '1, '1);
        sw = 1'b1; step(); sw = 1'b0;
        check("rs T+1 key", if3.o_key, '1);
        check("rs T+1 kv", 256'(if3.o_key_valid), 256'(1));
        step();
        check("rs T+2 stable", 256'(if3.o_keys_stable), '0);
        rst = 1'b1; step(); rst = 1'b0;
        check("rs key", if3.o_key, '0);
        check("rs stable", 256'(if3.o_keys_stable), '0);
        check("rs ready", 256'(if3.o_word_ready), 256'(1));
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rs after%0d kv", k), 256'(if3.o_key_valid), '0);
            check($sformatf("rs after%0d stable", k), 256'(if3.o_keys_stable), '0);
            check($sformatf("rs after%0d ready", k), 256'(if3.o_word_ready), 256'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
